// File: rtl/serial_demux_pkg.sv
// Shared definitions for the serial 1-to-WIDTH demultiplexer/deserializer.
package serial_demux_pkg;

  // Default word width and the matching index-counter width.
  localparam int WIDTH_DEF = 8;
  localparam int SEL_W_DEF = $clog2(WIDTH_DEF);

  // Index counter at the default width.
  typedef logic [SEL_W_DEF-1:0] sel_t;

  // Output-side occupancy: EMPTY when no word is offered, HELD while one waits.
  // The encoding is chosen so that the state bit is exactly out_valid.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } out_state_e;

  // Map a bit index within the word (0 = first bit received) to its position
  // in the assembled word.
  function automatic int idx_to_pos(input int sel, input bit lsb_first,
                                    input int width = WIDTH_DEF);
    return lsb_first ? sel : (width - 1 - sel);
  endfunction

endpackage

// File: rtl/bit_demux_dec.sv
// Position decoder: turns the index counter into a one-hot write enable for
// the shadow register, honouring the bit-ordering choice.
module bit_demux_dec
  import serial_demux_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] we
);

  // One-hot decode of sel into the word position it addresses
  always_comb begin
    we = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (sel == SEL_W'(i)) begin
        we[idx_to_pos(i, LSB_FIRST, WIDTH)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_demux8.sv
// Serial-in, word-out deserializer. Bits arrive one per input handshake and
// are steered into a shadow register at the position picked by the index
// counter; a finished word moves to out_data and is offered downstream while
// the shadow register keeps collecting the next word.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid keeps its data stable until the transfer;
// ready never depends combinationally on the same side's valid. in_ready only
// drops for the word-completing bit while a previous word is still waiting
// and is not being taken in this cycle.
module serial_demux8
  import serial_demux_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,      // power of two, at least 2
  parameter int SEL_W     = $clog2(WIDTH),  // derived, leave at default
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_sync,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SEL_W-1:0] sel,
  output logic             sync_err
);

  // Index of the last bit of a word, and the shadow mask for index 0.
  localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] POS0_MASK = WIDTH'(1) << idx_to_pos(0, LSB_FIRST, WIDTH);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [WIDTH-1:0] we;
  logic [WIDTH-1:0] merged;
  logic [SEL_W-1:0] sel_nxt;
  logic             at_last;
  logic             acc;
  logic             restart;
  logic             complete;
  out_state_e       state;
  out_state_e       state_nxt;

  bit_demux_dec #(
    .WIDTH     (WIDTH),
    .SEL_W     (SEL_W),
    .LSB_FIRST (LSB_FIRST)
  ) u_dec (
    .sel (sel),
    .we  (we)
  );

  // The next accepted bit would finish the word.
  assign at_last  = (sel == SEL_LAST);

  // Only the finishing bit is held back, and only while the output is occupied
  // and not draining this cycle.
  assign in_ready = !(out_valid && !out_ready && at_last);

  assign acc      = in_valid & in_ready;
  assign restart  = acc & in_sync;
  assign complete = acc & ~in_sync & at_last;

  // Shadow contents with the incoming bit written at the decoded position.
  assign merged   = in_bit ? (shadow | we) : (shadow & ~we);

  // Next shadow/counter: sync restarts at index 0, completion empties the
  // shadow, a plain bit just lands and advances the counter.
  always_comb begin
    shadow_nxt = shadow;
    sel_nxt    = sel;
    if (restart) begin
      shadow_nxt = in_bit ? POS0_MASK : '0;
      sel_nxt    = SEL_W'(1);
    end else if (complete) begin
      shadow_nxt = '0;
      sel_nxt    = '0;
    end else if (acc) begin
      shadow_nxt = merged;
      sel_nxt    = sel + 1'b1;
    end
  end

  // Datapath registers: shadow, counter, output word and sync error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow   <= '0;
      sel      <= '0;
      out_data <= '0;
      sync_err <= 1'b0;
    end else begin
      shadow   <= shadow_nxt;
      sel      <= sel_nxt;
      sync_err <= restart && (sel != '0);
      if (complete) begin
        out_data <= merged;
      end
    end
  end

  // Output occupancy state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Occupancy transitions: fill on completion, empty on drain without refill
  always_comb begin
    state_nxt = state;
    case (state)
      ST_EMPTY: if (complete) state_nxt = ST_HELD;
      ST_HELD:  if (out_ready && !complete) state_nxt = ST_EMPTY;
    endcase
  end

  // Output decode: the word is offered exactly while HELD
  always_comb begin
    out_valid = (state == ST_HELD);
  end

endmodule

// File: tb/tb_serial_demux8.sv
// Bench for serial_demux8: two instances (LSB-first and MSB-first) share one
// stimulus stream and are compared against a bit-list reference model.
module tb_serial_demux8;
  import serial_demux_pkg::*;

  localparam int W  = WIDTH_DEF;
  localparam int SW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_bit = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_sync = 1'b0;
  logic          out_ready = 1'b0;

  logic          in_ready_l, out_valid_l, sync_err_l;
  logic [W-1:0]  out_data_l;
  logic [SW-1:0] sel_l;
  logic          in_ready_m, out_valid_m, sync_err_m;
  logic [W-1:0]  out_data_m;
  logic [SW-1:0] sel_m;

  int checks_total  = 0;
  int checks_passed = 0;

  // Reference model: the bits of the word in progress, in arrival order,
  // plus the word currently offered downstream.
  int           cur_bits[$];
  bit           m_held;
  logic [W-1:0] m_data_l, m_data_m;
  bit           m_err;
  logic [W-1:0] exp_q[$];   // completed words (LSB-first) not yet taken

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- DUTs ----------------
  serial_demux8 #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_sync(in_sync), .in_ready(in_ready_l), .out_data(out_data_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .sel(sel_l),
    .sync_err(sync_err_l)
  );

  serial_demux8 #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst_n(rst_n), .in_bit(in_bit), .in_valid(in_valid),
    .in_sync(in_sync), .in_ready(in_ready_m), .out_data(out_data_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .sel(sel_m),
    .sync_err(sync_err_m)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Word value from the collected bits: k-th received bit goes to position k
  // (LSB first) or W-1-k (MSB first).
  function automatic logic [W-1:0] pack(input bit lsb);
    logic [W-1:0] w;
    w = '0;
    foreach (cur_bits[k]) w[lsb ? k : W-1-k] = (cur_bits[k] != 0);
    return w;
  endfunction

  task automatic model_reset();
    cur_bits.delete();
    exp_q.delete();
    m_held   = 1'b0;
    m_data_l = '0;
    m_data_m = '0;
    m_err    = 1'b0;
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_valid_l"}, 32'(out_valid_l), 32'(m_held));
    chk({tag, "_valid_m"}, 32'(out_valid_m), 32'(m_held));
    chk({tag, "_data_l"},  32'(out_data_l),  32'(m_data_l));
    chk({tag, "_data_m"},  32'(out_data_m),  32'(m_data_m));
    chk({tag, "_sel_l"},   32'(sel_l),       32'(cur_bits.size()));
    chk({tag, "_sel_m"},   32'(sel_m),       32'(cur_bits.size()));
    chk({tag, "_err_l"},   32'(sync_err_l),  32'(m_err));
    chk({tag, "_err_m"},   32'(sync_err_m),  32'(m_err));
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive at the falling edge, check ready before the rising
  // edge, advance the model, check registered outputs just after the edge.
  task automatic step(input bit v, input bit b, input bit s, input bit r);
    bit exp_rdy, acc, done;
    @(negedge clk);
    in_valid  = v;
    in_bit    = b;
    in_sync   = s;
    out_ready = r;
    #1;
    exp_rdy = !(m_held && !r && cur_bits.size() == W-1);
    chk("in_ready_l", 32'(in_ready_l), 32'(exp_rdy));
    chk("in_ready_m", 32'(in_ready_m), 32'(exp_rdy));
    if (out_valid_l && r) begin
      if (exp_q.size() == 0) chk("spurious_word", 32'(out_valid_l), 32'd0);
      else                   chk("taken_word", 32'(out_data_l), 32'(exp_q.pop_front()));
    end
    acc   = v && exp_rdy;
    done  = 1'b0;
    m_err = 1'b0;
    if (acc && s) begin
      m_err = (cur_bits.size() != 0);
      cur_bits.delete();
      cur_bits.push_back(int'(b));
    end else if (acc) begin
      cur_bits.push_back(int'(b));
      if (cur_bits.size() == W) begin
        done     = 1'b1;
        m_data_l = pack(1'b1);
        m_data_m = pack(1'b0);
        cur_bits.delete();
      end
    end
    if (done) begin
      m_held = 1'b1;
      exp_q.push_back(m_data_l);
    end else if (m_held && r) begin
      m_held = 1'b0;
    end
    @(posedge clk);
    #1;
    chk_outputs("step");
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    bit bits[8];
    model_reset();

    // Power-on reset
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset");
    chk("reset_in_ready", 32'(in_ready_l), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1,0,1,1,0,0,1,0 -> 4D (LSB first) / B2 (MSB first)
    bits = '{1, 0, 1, 1, 0, 0, 1, 0};
    for (int i = 0; i < 8; i++) step(1'b1, bits[i], 1'b0, 1'b1);
    chk("t1_data_l", 32'(out_data_l), 32'h4D);
    chk("t1_data_m", 32'(out_data_m), 32'hB2);
    chk("t1_valid", 32'(out_valid_l), 32'd1);
    chk("t1_sel", 32'(sel_l), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Hold FF, collect 7 bits of the next word, stall, then drain+complete
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_hold_data", 32'(out_data_l), 32'hFF);
    chk("t3_sel7", 32'(sel_l), 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_stall_sel", 32'(sel_l), 32'd7);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t3_new_data", 32'(out_data_l), 32'h00);
    chk("t3_valid_cont", 32'(out_valid_l), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Sync mid-word discards 3 bits
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t4_sync_err", 32'(sync_err_l), 32'd1);
    chk("t4_sel1", 32'(sel_l), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t4_data_l", 32'(out_data_l), 32'h01);
    chk("t4_data_m", 32'(out_data_m), 32'h80);
    chk("t4_err_gone", 32'(sync_err_l), 32'd0);

    // Sync on a word boundary, then sync without valid
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t5_no_err", 32'(sync_err_l), 32'd0);
    chk("t5_sel1", 32'(sel_l), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_sel_hold", 32'(sel_l), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) != 0);
    end

    // Reach sel=5 with a word held, then reset asynchronously
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), 1'b0, 1'b0);
    chk("t6_pre_sel", 32'(sel_l), 32'd5);
    chk("t6_pre_valid", 32'(out_valid_l), 32'd1);
    #2;
    in_valid = 1'b0;
    in_sync  = 1'b0;
    rst_n    = 1'b0;
    #1;
    model_reset();
    chk_outputs("async_rst");
    chk("async_rst_ready", 32'(in_ready_l), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Fresh word A5 after reset (palindromic bit pattern, same in both orders)
    bits = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) step(1'b1, bits[i], 1'b0, 1'b1);
    chk("t6_data_l", 32'(out_data_l), 32'hA5);
    chk("t6_data_m", 32'(out_data_m), 32'hA5);
    step(1'b0, 1'b0, 1'b0, 1'b1);

    // Final report
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule

// File: doc/serial_demux8.md
Name: serial_demux8

Overview:
- 1-to-8 serial demultiplexer and deserializer, the receive-side counterpart of the team's 8:1 bit multiplexer.
- Accepts one bit per valid/ready handshake.
- Steers each bit into the word position selected by an internal 3-bit index counter, then presents the completed 8-bit word on a valid/ready output.
- A shadow register keeps collecting the next word while the previous word waits to be taken.

Parameters:
- WIDTH, 8, word width in bits; must be a power of two, at least 2.
- SEL_W, $clog2(WIDTH), index counter width. Derived only; never overridden.
- LSB_FIRST, 1. 1: the first bit of a word lands in out_data[0]. 0: it lands in out_data[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_sync  input  1  qualified by in_valid; marks the current bit as bit 0 of a new word.
- in_ready  output  1  block accepts in_bit this cycle.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes out_data this cycle.
- sel  output  SEL_W  current index-counter value, i.e. the position for the next accepted bit.
- sync_err  output  1  one-cycle pulse: a partial word was discarded by in_sync.

Behaviour:
- Reset (async assert, sync deassert taken as given), all registers cleared:
  - sel=0, shadow=0, out_data=0, out_valid=0, sync_err=0.
  - in_ready reads 1 after reset.
- Accept: acc = in_valid & in_ready.
- Target position: pos = LSB_FIRST ? sel : WIDTH-1-sel.
- On acc without in_sync:
  - shadow[pos] <= in_bit.
  - sel <= sel+1, wrapping modulo WIDTH.
- On acc with in_sync:
  - The bit is written at the position for index 0.
  - sel <= 1.
  - Other shadow bits are cleared.
  - If sel != 0 at that moment, sync_err pulses 1 the next cycle; otherwise it stays 0.
- Word complete: acc while sel==WIDTH-1 and in_sync=0.
  - out_data <= shadow with the new bit merged in.
  - out_valid <= 1 on the next edge. Latency from the last bit accepted to out_valid is 1 cycle.
  - shadow <= 0 and sel <= 0.
  - Word completion with in_sync=1 is impossible, since in_sync restarts the word.
  - WIDTH=2 edge: a sync bit leaves sel=1=WIDTH-1, so the next non-sync bit completes the word.
- Output handshake:
  - out_valid & out_ready clears out_valid on the next edge, unless a new word completes in the same cycle; then out_valid stays 1 and out_data takes the new word.
  - While out_valid & !out_ready, out_data and out_valid hold stable.
- in_ready = !(out_valid & !out_ready & sel==WIDTH-1).
  - Only the word-completing bit is blocked while the output is occupied.
  - Bits 0..WIDTH-2 of the next word are always accepted.
  - in_ready is combinational from registers plus out_ready; there is no path from in_valid to in_ready.
- Conceptual states derive from out_valid: EMPTY (out_valid=0) and HELD (out_valid=1).
  - EMPTY->HELD on word completion.
  - HELD->EMPTY on out_ready with no completion.
  - HELD->HELD on stall, or on drain plus completion in the same cycle.
- When in_sync is asserted without in_valid, or without in_ready, it is ignored.
- Reset mid-word drops the partial word and any held word. No output is produced for them.
- in_bit is don't-care when in_valid=0. The counter advances only on acc.

Decomposition:
- Package serial_demux_pkg:
  - WIDTH_DEF=8.
  - Function idx_to_pos(sel, lsb_first).
  - typedef sel_t, logic[SEL_W-1:0] at the default width.
- No sub-module is required.
- The position decode may be factored as bit_demux_dec: SEL_W in, WIDTH one-hot write-enable out, combinational. It mirrors the existing 8:1 selection logic.

Test Plan:
- Reset, then in_bit sequence 1,0,1,1,0,0,1,0 on consecutive cycles with out_ready=1, LSB_FIRST=1 -> out_data=8'h4D, out_valid=1 exactly one cycle after the 8th bit, sel back to 0, in_ready never drops.
- Same 8 bits with LSB_FIRST=0 -> out_data=8'hB2.
- Word 8'hFF completed with out_ready=0; send 7 bits of 8'h00:
  - The 7 bits are accepted, out_data stays 8'hFF, and in_ready=0 at sel=7.
  - Raise out_ready on the stalled cycle -> the 8th bit is accepted that cycle, the next cycle out_data=8'h00 with out_valid=1 continuous.
- Send 3 bits, then in_valid=1 with in_sync=1 and in_bit=1 -> sync_err pulses once, sel=1. Then 7 more bits all 0 -> out_data=8'h01.
- in_sync on a word boundary (sel=0) -> no sync_err; in_sync=1 with in_valid=0 -> sel unchanged.
- Assert rst_n=0 asynchronously mid-word (sel=5) while out_valid=1 -> out_valid, out_data, sel, sync_err go to 0 immediately, without waiting for a clock edge. After release, a fresh 8-bit word 8'hA5 is assembled correctly.
